// File: rtl/pipe_ctrl.sv
// Pipeline control: prioritised stall vector, branch redirect sequencing,
// saturating stall-cycle counter and a sticky watchdog for a stuck ID hazard.
module pipe_ctrl #(
   parameter int CNT_W        = 32,
   parameter int MAX_ID_STALL = 15
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stallreq_if,
   input  logic             stallreq_id,
   input  logic             stallreq_ex,
   input  logic             stallreq_mem,
   input  logic             ex_branch_flag,
   input  logic [31:0]      ex_branch_target,
   output logic [5:0]       stall,
   output logic             flush,
   output logic [31:0]      new_pc,
   output logic [CNT_W-1:0] stall_cycles,
   output logic             hazard_err
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_PEND  = 2'd1;
   localparam logic [1:0] ST_FLUSH = 2'd2;

   localparam int WD_W = (MAX_ID_STALL < 1) ? 1 : $clog2(MAX_ID_STALL + 1);
   localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(MAX_ID_STALL);

   logic [1:0]      state;
   logic [31:0]     tgt_q;
   logic [5:0]      stall_req;
   logic            backend_busy;
   logic [WD_W-1:0] id_cnt;

   assign backend_busy = stallreq_ex | stallreq_mem;

   always_comb begin
      stall_req = 6'b000000;
      if (stallreq_mem)
         stall_req = 6'b011111;
      else if (stallreq_ex)
         stall_req = 6'b001111;
      else if (stallreq_id)
         stall_req = 6'b000111;
      else if (stallreq_if)
         stall_req = 6'b000011;
   end

   // A redirect in progress overrides the front-end stalls; back-end holds remain.
   assign flush  = (state == ST_FLUSH);
   assign new_pc = tgt_q;
   assign stall  = flush ? {stall_req[5:3], 3'b000} : stall_req;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ST_IDLE;
         tgt_q <= 32'h0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (ex_branch_flag) begin
                  tgt_q <= ex_branch_target;
                  state <= stall[3] ? ST_PEND : ST_FLUSH;
               end
            end
            ST_PEND: begin
               if (!backend_busy)
                  state <= ST_FLUSH;
            end
            ST_FLUSH: begin
               if (!backend_busy) begin
                  if (ex_branch_flag) begin
                     tgt_q <= ex_branch_target;
                     state <= stall[3] ? ST_PEND : ST_FLUSH;
                  end else begin
                     state <= ST_IDLE;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         stall_cycles <= '0;
      else if (stall[0] && (stall_cycles != {CNT_W{1'b1}}))
         stall_cycles <= stall_cycles + CNT_W'(1);
   end

   // Count saturates at the limit; one more ID-stalled edge trips the sticky flag.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         id_cnt     <= '0;
         hazard_err <= 1'b0;
      end else if (stallreq_id) begin
         if (id_cnt == WD_LIMIT)
            hazard_err <= 1'b1;
         else
            id_cnt <= id_cnt + WD_W'(1);
      end else begin
         id_cnt <= '0;
      end
   end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: stall priority, redirect timing, flush override,
// watchdog, counter saturation and asynchronous reset.
module tb_pipe_ctrl;

   logic        clk;
   logic        rst;
   logic        stallreq_if;
   logic        stallreq_id;
   logic        stallreq_ex;
   logic        stallreq_mem;
   logic        ex_branch_flag;
   logic [31:0] ex_branch_target;
   logic [5:0]  stall;
   logic        flush;
   logic [31:0] new_pc;
   logic [31:0] stall_cycles;
   logic        hazard_err;
   logic [5:0]  sat_stall;
   logic        sat_flush;
   logic [31:0] sat_new_pc;
   logic [3:0]  sat_cycles;
   logic        sat_err;

   int total;
   int bad;
   int exp_cycles;

   pipe_ctrl dut (
      .clk(clk), .rst(rst),
      .stallreq_if(stallreq_if), .stallreq_id(stallreq_id),
      .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
      .ex_branch_flag(ex_branch_flag), .ex_branch_target(ex_branch_target),
      .stall(stall), .flush(flush), .new_pc(new_pc),
      .stall_cycles(stall_cycles), .hazard_err(hazard_err)
   );

   pipe_ctrl #(.CNT_W(4), .MAX_ID_STALL(15)) dut_sat (
      .clk(clk), .rst(rst),
      .stallreq_if(stallreq_if), .stallreq_id(stallreq_id),
      .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
      .ex_branch_flag(ex_branch_flag), .ex_branch_target(ex_branch_target),
      .stall(sat_stall), .flush(sat_flush), .new_pc(sat_new_pc),
      .stall_cycles(sat_cycles), .hazard_err(sat_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      stallreq_if = 0; stallreq_id = 0; stallreq_ex = 0; stallreq_mem = 0;
      ex_branch_flag = 0; ex_branch_target = 32'h0;
   endtask

   task automatic test_reset();
      rst = 0;
      clear_inputs();
      #3;
      total++; if (stall !== 6'b000000) begin bad++; $display("[TB] FAIL reset_stall got=%b exp=000000", stall); end
      total++; if (flush !== 1'b0) begin bad++; $display("[TB] FAIL reset_flush got=%b exp=0", flush); end
      total++; if (new_pc !== 32'h0) begin bad++; $display("[TB] FAIL reset_new_pc got=%h exp=0", new_pc); end
      total++; if (stall_cycles !== 32'h0) begin bad++; $display("[TB] FAIL reset_cycles got=%0d exp=0", stall_cycles); end
      total++; if (hazard_err !== 1'b0) begin bad++; $display("[TB] FAIL reset_err got=%b exp=0", hazard_err); end
      tick();
      rst = 1;
      tick();
      exp_cycles = 0;
   endtask

   task automatic test_stall_priority();
      stallreq_id = 1; #1;
      total++; if (stall !== 6'b000111) begin bad++; $display("[TB] FAIL prio_id got=%b exp=000111", stall); end
      tick(); exp_cycles++;
      stallreq_mem = 1; #1;
      total++; if (stall !== 6'b011111) begin bad++; $display("[TB] FAIL prio_id_mem got=%b exp=011111", stall); end
      tick(); exp_cycles++;
      stallreq_id = 0; stallreq_mem = 0; stallreq_if = 1; #1;
      total++; if (stall !== 6'b000011) begin bad++; $display("[TB] FAIL prio_if got=%b exp=000011", stall); end
      tick(); exp_cycles++;
      stallreq_ex = 1; #1;
      total++; if (stall !== 6'b001111) begin bad++; $display("[TB] FAIL prio_ex_if got=%b exp=001111", stall); end
      tick(); exp_cycles++;
      clear_inputs(); #1;
      total++; if (stall !== 6'b000000) begin bad++; $display("[TB] FAIL prio_none got=%b exp=000000", stall); end
      tick();
      total++; if (stall_cycles !== 32'(exp_cycles)) begin bad++; $display("[TB] FAIL prio_cycles got=%0d exp=%0d", stall_cycles, exp_cycles); end
   endtask

   task automatic test_branch();
      ex_branch_flag = 1; ex_branch_target = 32'h0000_0100; #1;
      total++; if (flush !== 1'b0) begin bad++; $display("[TB] FAIL br_pre_flush got=%b exp=0", flush); end
      tick();
      clear_inputs(); #1;
      total++; if (flush !== 1'b1) begin bad++; $display("[TB] FAIL br_flush got=%b exp=1", flush); end
      total++; if (new_pc !== 32'h100) begin bad++; $display("[TB] FAIL br_new_pc got=%h exp=100", new_pc); end
      tick();
      total++; if (flush !== 1'b0) begin bad++; $display("[TB] FAIL br_flush_n2 got=%b exp=0", flush); end
   endtask

   task automatic test_branch_pend();
      ex_branch_flag = 1; ex_branch_target = 32'h200; stallreq_mem = 1;
      tick(); exp_cycles++;
      ex_branch_target = 32'h300; #1;
      total++; if (flush !== 1'b0) begin bad++; $display("[TB] FAIL pend_flush1 got=%b exp=0", flush); end
      tick(); exp_cycles++;
      ex_branch_flag = 0; #1;
      total++; if (flush !== 1'b0) begin bad++; $display("[TB] FAIL pend_flush2 got=%b exp=0", flush); end
      tick(); exp_cycles++;
      stallreq_mem = 0; #1;
      total++; if (flush !== 1'b0) begin bad++; $display("[TB] FAIL pend_flush3 got=%b exp=0", flush); end
      tick();
      total++; if (flush !== 1'b1) begin bad++; $display("[TB] FAIL pend_flush got=%b exp=1", flush); end
      total++; if (new_pc !== 32'h200) begin bad++; $display("[TB] FAIL pend_new_pc got=%h exp=200", new_pc); end
      tick();
      total++; if (flush !== 1'b0) begin bad++; $display("[TB] FAIL pend_done got=%b exp=0", flush); end
   endtask

   task automatic test_flush_override();
      ex_branch_flag = 1; ex_branch_target = 32'h400;
      tick();
      ex_branch_flag = 0; stallreq_id = 1; stallreq_if = 1; #1;
      total++; if (stall !== 6'b000000) begin bad++; $display("[TB] FAIL ovr_stall got=%b exp=000000", stall); end
      total++; if (flush !== 1'b1) begin bad++; $display("[TB] FAIL ovr_flush got=%b exp=1", flush); end
      stallreq_ex = 1; #1;
      total++; if (stall !== 6'b001000) begin bad++; $display("[TB] FAIL ovr_ex_stall got=%b exp=001000", stall); end
      tick();
      clear_inputs(); #1;
      total++; if (flush !== 1'b1) begin bad++; $display("[TB] FAIL ovr_held got=%b exp=1", flush); end
      total++; if (new_pc !== 32'h400) begin bad++; $display("[TB] FAIL ovr_new_pc got=%h exp=400", new_pc); end
      tick();
      total++; if (flush !== 1'b0) begin bad++; $display("[TB] FAIL ovr_done got=%b exp=0", flush); end
      total++; if (stall_cycles !== 32'(exp_cycles)) begin bad++; $display("[TB] FAIL ovr_cycles got=%0d exp=%0d", stall_cycles, exp_cycles); end
   endtask

   task automatic test_back_to_back();
      ex_branch_flag = 1; ex_branch_target = 32'h600;
      tick();
      ex_branch_target = 32'h700; #1;
      total++; if (new_pc !== 32'h600 || flush !== 1'b1) begin bad++; $display("[TB] FAIL b2b_first got=%h/%b exp=600/1", new_pc, flush); end
      tick();
      clear_inputs(); #1;
      total++; if (new_pc !== 32'h700 || flush !== 1'b1) begin bad++; $display("[TB] FAIL b2b_second got=%h/%b exp=700/1", new_pc, flush); end
      tick();
      total++; if (flush !== 1'b0) begin bad++; $display("[TB] FAIL b2b_done got=%b exp=0", flush); end
   endtask

   task automatic test_watchdog();
      stallreq_id = 1;
      for (int i = 0; i < 15; i++) begin
         tick(); exp_cycles++;
      end
      total++; if (hazard_err !== 1'b0) begin bad++; $display("[TB] FAIL wd_early got=%b exp=0", hazard_err); end
      tick(); exp_cycles++;
      total++; if (hazard_err !== 1'b1) begin bad++; $display("[TB] FAIL wd_set got=%b exp=1", hazard_err); end
      stallreq_id = 0;
      tick(); tick();
      total++; if (hazard_err !== 1'b1) begin bad++; $display("[TB] FAIL wd_sticky got=%b exp=1", hazard_err); end
   endtask

   task automatic test_saturation();
      stallreq_id = 1;
      for (int i = 0; i < 20; i++) begin
         tick(); exp_cycles++;
      end
      stallreq_id = 0; #1;
      total++; if (sat_cycles !== 4'hF) begin bad++; $display("[TB] FAIL sat_hold got=%h exp=f", sat_cycles); end
      total++; if (stall_cycles !== 32'(exp_cycles)) begin bad++; $display("[TB] FAIL sat_wide got=%0d exp=%0d", stall_cycles, exp_cycles); end
   endtask

   task automatic test_reset_mid_pend();
      ex_branch_flag = 1; ex_branch_target = 32'h800; stallreq_mem = 1;
      tick();
      ex_branch_flag = 0; #2;
      rst = 0; #1;
      total++; if (flush !== 1'b0) begin bad++; $display("[TB] FAIL rstp_flush got=%b exp=0", flush); end
      total++; if (new_pc !== 32'h0) begin bad++; $display("[TB] FAIL rstp_new_pc got=%h exp=0", new_pc); end
      total++; if (stall_cycles !== 32'h0) begin bad++; $display("[TB] FAIL rstp_cycles got=%0d exp=0", stall_cycles); end
      total++; if (hazard_err !== 1'b0) begin bad++; $display("[TB] FAIL rstp_err got=%b exp=0", hazard_err); end
      total++; if (stall !== 6'b011111) begin bad++; $display("[TB] FAIL rstp_stall got=%b exp=011111", stall); end
      stallreq_mem = 0;
      tick();
      rst = 1;
      tick();
      total++; if (flush !== 1'b0) begin bad++; $display("[TB] FAIL rstp_post1 got=%b exp=0", flush); end
      tick();
      total++; if (flush !== 1'b0) begin bad++; $display("[TB] FAIL rstp_post2 got=%b exp=0", flush); end
   endtask

   initial begin
      total = 0;
      bad = 0;
      exp_cycles = 0;
      test_reset();
      test_stall_priority();
      test_branch();
      test_branch_pend();
      test_flush_override();
      test_back_to_back();
      test_watchdog();
      test_saturation();
      test_reset_mid_pend();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
